tensor_core_instruction_scheduler: RTL and testbench

Arbitrates 16-bit instruction streams from REQ_COUNT requesters onto the single `current_instruction` bus of the cpu/tensor-core datapath. Enforces multi-cycle occupancy rules, so no requester can corrupt an in-flight operation:
- burst header and data beats stay locked to one requester;
- NOPs are inserted while a burst read drains;
- NOPs are inserted while a tensor-core operate is in progress.

Output is registered and drives the cpu instruction input directly.

---
 rtl/tensor_core_instruction_scheduler.sv | 165 ++++++++++++++++
 tb/tb_tensor_core_instruction_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_instruction_scheduler.sv
// Instruction scheduler: arbitrates requester streams onto the cpu instruction bus, with burst/operate locks.
// Define SCHEDULER_FIXED_PRIORITY_EN for lowest-index-wins arbitration (default: round-robin).
//
// state    | meaning
// ARB      | arbitrate requesters, decode the accepted word
// BURST_WR | forward owner data beats unmodified
// BURST_RD | emit NOPs while the burst read drains
// OP_WAIT  | emit NOPs while the tensor-core operate runs
module tensor_core_instruction_scheduler #(
  parameter int REQ_COUNT       = 2,
  parameter int INSTR_WIDTH     = 16,
  parameter int BURST_BEATS     = 5,
  parameter int OPERATE_LATENCY = 5,
  localparam int IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                               clock_in,
  input  logic                               reset_in,
  input  logic [REQ_COUNT-1:0]               req_valid_in,
  input  logic [REQ_COUNT*INSTR_WIDTH-1:0]   req_instruction_in,
  output logic [REQ_COUNT-1:0]               req_ready_out,
  output logic [INSTR_WIDTH-1:0]             instruction_out,
  output logic                               instruction_valid_out,
  output logic [IDX_W-1:0]                   grant_index_out,
  output logic                               busy_out,
  output logic                               burst_underrun_out
);

  localparam logic [1:0] ARB      = 2'd0;
  localparam logic [1:0] BURST_WR = 2'd1;
  localparam logic [1:0] BURST_RD = 2'd2;
  localparam logic [1:0] OP_WAIT  = 2'd3;

  localparam int BEAT_W = $clog2(BURST_BEATS + 1);
  localparam int WAIT_W = $clog2(OPERATE_LATENCY + 1);

  logic [1:0]             state;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [IDX_W-1:0]       owner_idx;
  logic [IDX_W-1:0]       scan_base;
  logic [IDX_W-1:0]       win_idx;
  logic                   found;
  int                     scan;
  logic [INSTR_WIDTH-1:0] req_word [REQ_COUNT];
  logic [INSTR_WIDTH-1:0] win_word;
  logic [1:0]             opcode;
  logic [1:0]             sel;

  for (genvar g = 0; g < REQ_COUNT; g++) begin : g_split
    assign req_word[g] = req_instruction_in[g*INSTR_WIDTH +: INSTR_WIDTH];
  end

`ifdef SCHEDULER_FIXED_PRIORITY_EN
  assign scan_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;

  assign scan_base = rr_ptr;
  assign next_ptr  = (int'(win_idx) == REQ_COUNT - 1) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clock_in) begin
    if (reset_in)
      rr_ptr <= '0;
    else if (state == ARB && found)
      rr_ptr <= next_ptr;
  end
`endif

  // First valid requester at or above scan_base, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      scan = int'(scan_base) + k;
      if (scan >= REQ_COUNT) scan = scan - REQ_COUNT;
      if (!found && req_valid_in[IDX_W'(scan)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(scan);
      end
    end
  end

  assign win_word = req_word[win_idx];
  assign opcode   = win_word[1:0];
  assign sel      = win_word[3:2];

  always_comb begin
    req_ready_out = '0;
    if (!reset_in) begin
      if (state == ARB)
        req_ready_out[win_idx] = found;
      else if (state == BURST_WR)
        req_ready_out[owner_idx] = 1'b1;
    end
  end

  assign busy_out = (state != ARB);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                 <= ARB;
      beat_cnt              <= '0;
      wait_cnt              <= '0;
      owner_idx             <= '0;
      instruction_out       <= '0;
      instruction_valid_out <= 1'b0;
      grant_index_out       <= '0;
      burst_underrun_out    <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            instruction_out       <= win_word;
            instruction_valid_out <= 1'b1;
            grant_index_out       <= win_idx;
            if (opcode == 2'b11 && (sel == 2'b01 || sel == 2'b10)) begin
              state     <= BURST_WR;
              beat_cnt  <= BEAT_W'(BURST_BEATS);
              owner_idx <= win_idx;
            end else if (opcode == 2'b11 && sel == 2'b00) begin
              state    <= BURST_RD;
              beat_cnt <= BEAT_W'(BURST_BEATS);
            end else if (opcode == 2'b10) begin
              state    <= OP_WAIT;
              wait_cnt <= WAIT_W'(OPERATE_LATENCY);
            end
          end else begin
            instruction_out       <= '0;
            instruction_valid_out <= 1'b0;
          end
        end
        BURST_WR: begin
          // A missing beat still consumes a slot: the cpu burst index advances regardless.
          if (req_valid_in[owner_idx]) begin
            instruction_out       <= req_word[owner_idx];
            instruction_valid_out <= 1'b1;
            grant_index_out       <= owner_idx;
          end else begin
            instruction_out       <= '0;
            instruction_valid_out <= 1'b0;
            burst_underrun_out    <= 1'b1;
          end
          beat_cnt <= beat_cnt - 1'b1;
          if (beat_cnt == BEAT_W'(1)) state <= ARB;
        end
        BURST_RD: begin
          instruction_out       <= '0;
          instruction_valid_out <= 1'b0;
          beat_cnt              <= beat_cnt - 1'b1;
          if (beat_cnt == BEAT_W'(1)) state <= ARB;
        end
        OP_WAIT: begin
          instruction_out       <= '0;
          instruction_valid_out <= 1'b0;
          wait_cnt              <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_W'(1)) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_instruction_scheduler.sv
// Directed bench for tensor_core_instruction_scheduler in its default round-robin build.
module tb_tensor_core_instruction_scheduler;

  logic        clock_in;
  logic        reset_in;
  logic [1:0]  req_valid_in;
  logic [31:0] req_instruction_in;
  logic [1:0]  req_ready_out;
  logic [15:0] instruction_out;
  logic        instruction_valid_out;
  logic [0:0]  grant_index_out;
  logic        busy_out;
  logic        burst_underrun_out;

  int checks   = 0;
  int failures = 0;

  tensor_core_instruction_scheduler dut (
    .clock_in              (clock_in),
    .reset_in              (reset_in),
    .req_valid_in          (req_valid_in),
    .req_instruction_in    (req_instruction_in),
    .req_ready_out         (req_ready_out),
    .instruction_out       (instruction_out),
    .instruction_valid_out (instruction_valid_out),
    .grant_index_out       (grant_index_out),
    .busy_out              (busy_out),
    .burst_underrun_out    (burst_underrun_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #2;
  endtask

  task automatic do_reset();
    reset_in           = 1'b1;
    req_valid_in       = 2'b00;
    req_instruction_in = '0;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (instruction_out !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", instruction_out); end
    checks++; if (instruction_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instruction_valid_out); end
    checks++; if (grant_index_out !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", grant_index_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    checks++; if (burst_underrun_out !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", burst_underrun_out); end
    checks++; if (req_ready_out !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready_out); end
    tick();
    checks++; if (instruction_valid_out !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", instruction_valid_out); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_w;
    do_reset();
    req_valid_in       = 2'b11;
    req_instruction_in = {16'h1001, 16'h0801};
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (req_ready_out !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b", i, req_ready_out); end
      tick();
      exp_w = (i % 2 == 0) ? 16'h0801 : 16'h1001;
      checks++; if (instruction_out !== exp_w) begin failures++; $display("FAIL rr_instr cyc=%0d got=%h exp=%h", i, instruction_out, exp_w); end
      checks++; if (grant_index_out !== 1'(i % 2)) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%0d", i, grant_index_out, i % 2); end
      checks++; if (instruction_valid_out !== 1'b1) begin failures++; $display("FAIL rr_valid cyc=%0d got=%b exp=1", i, instruction_valid_out); end
    end
  endtask

  task automatic test_burst_write();
    logic [15:0] data [5];
    data[0] = 16'h0007; data[1] = 16'h0003; data[2] = 16'h0002; data[3] = 16'h1234; data[4] = 16'hFFFF;
    do_reset();
    req_valid_in       = 2'b11;
    req_instruction_in = {16'h1001, 16'h0007};
    tick();
    checks++; if (instruction_out !== 16'h0007 || grant_index_out !== 1'b0) begin failures++; $display("FAIL bw_header got=%h/%b exp=0007/0", instruction_out, grant_index_out); end
    checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL bw_busy got=%b exp=1", busy_out); end
    for (int b = 0; b < 5; b++) begin
      req_instruction_in = {16'h1001, data[b]};
      #1;
      checks++; if (req_ready_out !== 2'b01) begin failures++; $display("FAIL bw_ready beat=%0d got=%b exp=01", b, req_ready_out); end
      tick();
      checks++; if (instruction_out !== data[b] || grant_index_out !== 1'b0 || instruction_valid_out !== 1'b1) begin
        failures++; $display("FAIL bw_beat beat=%0d got=%h/%b/%b exp=%h/0/1", b, instruction_out, grant_index_out, instruction_valid_out, data[b]);
      end
    end
    req_instruction_in = {16'h1001, 16'h0801};
    #1;
    checks++; if (busy_out !== 1'b0 || req_ready_out !== 2'b10) begin failures++; $display("FAIL bw_release got busy=%b ready=%b exp 0/10", busy_out, req_ready_out); end
    tick();
    checks++; if (instruction_out !== 16'h1001 || grant_index_out !== 1'b1) begin failures++; $display("FAIL bw_next got=%h/%b exp=1001/1", instruction_out, grant_index_out); end
    checks++; if (burst_underrun_out !== 1'b0) begin failures++; $display("FAIL bw_underrun got=%b exp=0", burst_underrun_out); end
  endtask

  task automatic test_operate();
    do_reset();
    req_valid_in       = 2'b10;
    req_instruction_in = {16'h0002, 16'h0000};
    #1;
    checks++; if (req_ready_out !== 2'b10) begin failures++; $display("FAIL op_ready0 got=%b exp=10", req_ready_out); end
    tick();
    checks++; if (instruction_out !== 16'h0002 || grant_index_out !== 1'b1 || instruction_valid_out !== 1'b1) begin
      failures++; $display("FAIL op_instr got=%h/%b/%b exp=0002/1/1", instruction_out, grant_index_out, instruction_valid_out);
    end
    req_instruction_in = {16'h0801, 16'h0000};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready_out !== 2'b00 || busy_out !== 1'b1) begin failures++; $display("FAIL op_stall k=%0d got ready=%b busy=%b exp 00/1", k, req_ready_out, busy_out); end
      tick();
      checks++; if (instruction_out !== 16'h0000 || instruction_valid_out !== 1'b0) begin failures++; $display("FAIL op_nop k=%0d got=%h/%b exp=0000/0", k, instruction_out, instruction_valid_out); end
    end
    #1;
    checks++; if (busy_out !== 1'b0 || req_ready_out !== 2'b10) begin failures++; $display("FAIL op_release got busy=%b ready=%b exp 0/10", busy_out, req_ready_out); end
    tick();
    checks++; if (instruction_out !== 16'h0801 || instruction_valid_out !== 1'b1) begin failures++; $display("FAIL op_next got=%h/%b exp=0801/1", instruction_out, instruction_valid_out); end
  endtask

  task automatic test_underrun();
    do_reset();
    req_valid_in       = 2'b01;
    req_instruction_in = {16'h0000, 16'h000B};
    tick();
    checks++; if (instruction_out !== 16'h000B) begin failures++; $display("FAIL ur_header got=%h exp=000B", instruction_out); end
    for (int b = 0; b < 5; b++) begin
      req_valid_in       = (b == 2) ? 2'b00 : 2'b01;
      req_instruction_in = {16'h0000, 16'h5550 + 16'(b)};
      tick();
      if (b == 2) begin
        checks++; if (instruction_out !== 16'h0000 || instruction_valid_out !== 1'b0) begin failures++; $display("FAIL ur_gap got=%h/%b exp=0000/0", instruction_out, instruction_valid_out); end
      end else begin
        checks++; if (instruction_out !== 16'h5550 + 16'(b) || instruction_valid_out !== 1'b1) begin failures++; $display("FAIL ur_beat beat=%0d got=%h/%b", b, instruction_out, instruction_valid_out); end
      end
      checks++; if (burst_underrun_out !== (b >= 2)) begin failures++; $display("FAIL ur_flag beat=%0d got=%b exp=%b", b, burst_underrun_out, b >= 2); end
    end
    req_valid_in       = 2'b01;
    req_instruction_in = {16'h0000, 16'h0801};
    #1;
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL ur_release got busy=%b exp=0", busy_out); end
    tick();
    checks++; if (instruction_out !== 16'h0801 || burst_underrun_out !== 1'b1) begin failures++; $display("FAIL ur_sticky got=%h/%b exp=0801/1", instruction_out, burst_underrun_out); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_valid_in       = 2'b01;
    req_instruction_in = {16'h0000, 16'h0002};
    tick();
    req_valid_in = 2'b00;
    tick();
    reset_in           = 1'b1;
    req_valid_in       = 2'b10;
    req_instruction_in = {16'h1001, 16'h0000};
    #1;
    checks++; if (req_ready_out !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", req_ready_out); end
    tick();
    reset_in           = 1'b0;
    req_valid_in       = 2'b11;
    req_instruction_in = {16'h1001, 16'h0801};
    #1;
    checks++; if (instruction_out !== 16'h0000 || instruction_valid_out !== 1'b0 || grant_index_out !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got=%h/%b/%b exp=0000/0/0", instruction_out, instruction_valid_out, grant_index_out);
    end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_out); end
    checks++; if (req_ready_out !== 2'b01) begin failures++; $display("FAIL rst_ptr got ready=%b exp=01", req_ready_out); end
    tick();
    checks++; if (instruction_out !== 16'h0801 || grant_index_out !== 1'b0) begin failures++; $display("FAIL rst_accept got=%h/%b exp=0801/0", instruction_out, grant_index_out); end
  endtask

  task automatic test_burst_read();
    do_reset();
    req_valid_in       = 2'b01;
    req_instruction_in = {16'h0000, 16'h0003};
    tick();
    checks++; if (instruction_out !== 16'h0003 || instruction_valid_out !== 1'b1) begin failures++; $display("FAIL br_header got=%h/%b exp=0003/1", instruction_out, instruction_valid_out); end
    req_valid_in       = 2'b11;
    req_instruction_in = {16'h1001, 16'h0801};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready_out !== 2'b00 || busy_out !== 1'b1) begin failures++; $display("FAIL br_stall k=%0d got ready=%b busy=%b exp 00/1", k, req_ready_out, busy_out); end
      tick();
      checks++; if (instruction_out !== 16'h0000 || instruction_valid_out !== 1'b0) begin failures++; $display("FAIL br_nop k=%0d got=%h/%b exp=0000/0", k, instruction_out, instruction_valid_out); end
    end
    #1;
    checks++; if (req_ready_out !== 2'b10) begin failures++; $display("FAIL br_release got ready=%b exp=10", req_ready_out); end
    tick();
    checks++; if (instruction_out !== 16'h1001 || grant_index_out !== 1'b1) begin failures++; $display("FAIL br_next got=%h/%b exp=1001/1", instruction_out, grant_index_out); end
  endtask

  task automatic test_passthrough();
    do_reset();
    req_valid_in       = 2'b01;
    req_instruction_in = {16'h0000, 16'h000F};
    tick();
    checks++; if (instruction_out !== 16'h000F || busy_out !== 1'b0) begin failures++; $display("FAIL pt_reserved got=%h busy=%b exp=000F/0", instruction_out, busy_out); end
    req_instruction_in = {16'h0000, 16'h000C};
    tick();
    checks++; if (instruction_out !== 16'h000C || instruction_valid_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++; $display("FAIL pt_generic_reset got=%h/%b busy=%b exp=000C/1/0", instruction_out, instruction_valid_out, busy_out);
    end
  endtask

  initial begin
    reset_in           = 1'b1;
    req_valid_in       = 2'b00;
    req_instruction_in = '0;
    test_reset();
    test_round_robin();
    test_burst_write();
    test_operate();
    test_underrun();
    test_reset_mid_op();
    test_burst_read();
    test_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
